// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART with AXI-Stream-style byte ports.
// RX deserializes rxd onto m_axis; TX serializes s_axis onto txd.
// Bit period is prescale*8 clocks (prescale 0 behaves as 1), latched per frame.
// Optional build macro UART_LOOPBACK_EN: the RX synchronizer takes the internal
// txd register instead of the rxd pin; txd still drives the pin.
module uart_transceiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           prescale,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  tx_busy
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // A zero divider would stall the bit counters, so it is promoted to 1.
    function automatic logic [15:0] eff_prescale(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

    logic [15:0] prescale_eff_s;
    logic [18:0] bit_period_s;
    logic [18:0] half_period_s;
    logic        rx_line_s;

    assign prescale_eff_s = eff_prescale(prescale);
    assign bit_period_s   = {prescale_eff_s, 3'b000};
    assign half_period_s  = {1'b0, prescale_eff_s, 2'b00};

`ifdef UART_LOOPBACK_EN
    assign rx_line_s = txd;
`else
    assign rx_line_s = rxd;
`endif

    logic                  rx_meta_r;
    logic                  rx_sync_r;
    rx_state_t             rx_state_r;
    logic [18:0]           rx_cnt_r;
    logic [18:0]           rx_period_r;
    logic [BIT_CNT_W-1:0]  rx_bits_r;
    logic [DATA_WIDTH-1:0] rx_shift_r;

    tx_state_t             tx_state_r;
    logic [18:0]           tx_cnt_r;
    logic [18:0]           tx_period_r;
    logic [BIT_CNT_W-1:0]  tx_bits_r;
    logic [DATA_WIDTH-1:0] tx_shift_r;

    // Two-flop synchronizer for the asynchronous serial input, preset to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_line_s;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM: mid-bit sampling, byte hand-off to m_axis and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r       <= RX_IDLE;
            rx_cnt_r         <= 19'd0;
            rx_period_r      <= 19'd0;
            rx_bits_r        <= '0;
            rx_shift_r       <= '0;
            m_axis_tdata     <= '0;
            m_axis_tvalid    <= 1'b0;
            rx_busy          <= 1'b0;
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
        end else begin
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
            // A completing byte later in this block overrides the clear.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (rx_state_r)
                RX_IDLE: begin
                    if (!rx_sync_r) begin
                        rx_state_r  <= RX_START;
                        rx_busy     <= 1'b1;
                        rx_period_r <= bit_period_s;
                        rx_cnt_r    <= half_period_s - 19'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r != 19'd0) begin
                        rx_cnt_r <= rx_cnt_r - 19'd1;
                    end else if (rx_sync_r) begin
                        // Line back high at mid start bit: a glitch, not a frame.
                        rx_state_r <= RX_IDLE;
                        rx_busy    <= 1'b0;
                    end else begin
                        rx_state_r <= RX_DATA;
                        rx_cnt_r   <= rx_period_r - 19'd1;
                        rx_bits_r  <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r != 19'd0) begin
                        rx_cnt_r <= rx_cnt_r - 19'd1;
                    end else begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_WIDTH-1:1]};
                        rx_cnt_r   <= rx_period_r - 19'd1;
                        if (rx_bits_r == LAST_BIT) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bits_r <= rx_bits_r + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r != 19'd0) begin
                        rx_cnt_r <= rx_cnt_r - 19'd1;
                    end else begin
                        rx_busy <= 1'b0;
                        if (rx_sync_r) begin
                            m_axis_tdata  <= rx_shift_r;
                            m_axis_tvalid <= 1'b1;
                            if (m_axis_tvalid && !m_axis_tready) begin
                                rx_overrun_error <= 1'b1;
                            end
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_frame_error <= 1'b1;
                            rx_state_r     <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    // Hold off through a break so a long low does not start a frame.
                    if (rx_sync_r) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Transmit FSM: accept a byte, then shift start, data (LSB first) and stop bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r    <= TX_IDLE;
            tx_cnt_r      <= 19'd0;
            tx_period_r   <= 19'd0;
            tx_bits_r     <= '0;
            tx_shift_r    <= '0;
            txd           <= 1'b1;
            tx_busy       <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (s_axis_tvalid && s_axis_tready) begin
                        tx_shift_r    <= s_axis_tdata;
                        s_axis_tready <= 1'b0;
                        tx_busy       <= 1'b1;
                        txd           <= 1'b0;
                        tx_period_r   <= bit_period_s;
                        tx_cnt_r      <= bit_period_s - 19'd1;
                        tx_state_r    <= TX_START;
                    end else begin
                        s_axis_tready <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r != 19'd0) begin
                        tx_cnt_r <= tx_cnt_r - 19'd1;
                    end else begin
                        txd        <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[DATA_WIDTH-1:1]};
                        tx_bits_r  <= '0;
                        tx_cnt_r   <= tx_period_r - 19'd1;
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r != 19'd0) begin
                        tx_cnt_r <= tx_cnt_r - 19'd1;
                    end else begin
                        tx_cnt_r <= tx_period_r - 19'd1;
                        if (tx_bits_r == LAST_BIT) begin
                            txd        <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            txd        <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[DATA_WIDTH-1:1]};
                            tx_bits_r  <= tx_bits_r + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r != 19'd0) begin
                        tx_cnt_r <= tx_cnt_r - 19'd1;
                    end else begin
                        tx_busy       <= 1'b0;
                        s_axis_tready <= 1'b1;
                        tx_state_r    <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_r    <= TX_IDLE;
                    txd           <= 1'b1;
                    tx_busy       <= 1'b0;
                    s_axis_tready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at prescale=2 (16 clocks per bit).
module tb_uart_transceiver;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale;
    logic        rxd;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        rx_busy;
    logic        rx_ovr;
    logic        rx_ferr;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        txd;
    logic        tx_busy;

    // loop_mode wires m_axis straight into s_axis (echo); otherwise the bench drives both.
    logic        loop_mode;
    logic [7:0]  drv_tdata;
    logic        drv_tvalid;
    logic        drv_mtready;

    assign s_tdata  = loop_mode ? m_tdata  : drv_tdata;
    assign s_tvalid = loop_mode ? m_tvalid : drv_tvalid;
    assign m_tready = loop_mode ? s_tready : drv_mtready;

    int err_cnt = 0;
    int chk_cnt = 0;

    uart_transceiver #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .rxd(rxd),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .rx_busy(rx_busy), .rx_overrun_error(rx_ovr), .rx_frame_error(rx_ferr),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .txd(txd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bytes handed off on m_axis, and pulse/valid counters, all sampled on negedge.
    logic [7:0] rx_q[$];
    int ov_cnt = 0;
    int fe_cnt = 0;
    int vld_cnt = 0;
    always @(negedge clk) begin
        if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
        if (rx_ovr) ov_cnt++;
        if (rx_ferr) fe_cnt++;
        if (m_tvalid) vld_cnt++;
    end

    // txd decoder: 10 mid-bit samples per frame, bit 0 = start, bit 9 = stop.
    logic [9:0] tx_q[$];
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_bit = 0;
    logic [9:0] mon_frm = 10'd0;
    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 7;
                mon_bit = 0;
            end
        end else if (mon_cnt != 0) begin
            mon_cnt--;
        end else begin
            mon_frm[mon_bit] = txd;
            if (mon_bit == 9) begin
                tx_q.push_back(mon_frm);
                mon_act = 1'b0;
            end else begin
                mon_bit++;
                mon_cnt = 15;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        tx_q.delete();
        ov_cnt = 0;
        fe_cnt = 0;
        vld_cnt = 0;
    endtask

    initial begin
        int lo;
        int bz;
        rst = 1'b1; prescale = 16'd2; rxd = 1'b1;
        loop_mode = 1'b0; drv_tdata = 8'h00; drv_tvalid = 1'b0; drv_mtready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_txd", {31'd0, txd}, 32'd1);
        check_val("rst_tdata", {24'd0, m_tdata}, 32'h0);
        check_val("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check_val("rst_tready", {31'd0, s_tready}, 32'd0);
        check_val("rst_busy", {30'd0, rx_busy, tx_busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("tready_after_rst", {31'd0, s_tready}, 32'd1);
        repeat (4) @(negedge clk);
        clear_mon();

`ifdef UART_LOOPBACK_EN
        // Loopback: s_axis byte comes back on m_axis while rxd stays idle.
        drv_tdata = 8'h5A; drv_tvalid = 1'b1;
        @(negedge clk);
        drv_tvalid = 1'b0;
        repeat (220) @(negedge clk);
        check_val("lb_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check_val("lb_byte", {24'd0, rx_q[0]}, 32'h5A);
        check_val("lb_frame_count", tx_q.size(), 32'd1);
        if (tx_q.size() > 0) check_val("lb_frame", {22'd0, tx_q[0]}, 32'h25A << 0 == 32'h25A ? {22'd0, 10'b1010110100} : 32'd0);
`else
        // 1: RX frames echoed through TX.
        loop_mode = 1'b1;
        send_rx(8'h55, 1'b1); repeat (20) @(negedge clk);
        send_rx(8'hA3, 1'b1); repeat (20) @(negedge clk);
        send_rx(8'hFF, 1'b1);
        repeat (400) @(negedge clk);
        check_val("echo_rx_count", rx_q.size(), 32'd3);
        check_val("echo_tx_count", tx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            check_val("echo_rx0", {24'd0, rx_q[0]}, 32'h55);
            check_val("echo_rx1", {24'd0, rx_q[1]}, 32'hA3);
            check_val("echo_rx2", {24'd0, rx_q[2]}, 32'hFF);
        end
        if (tx_q.size() == 3) begin
            check_val("echo_tx0", {22'd0, tx_q[0]}, 32'h2AA);
            check_val("echo_tx1", {22'd0, tx_q[1]}, 32'h346);
            check_val("echo_tx2", {22'd0, tx_q[2]}, 32'h3FE);
        end
        loop_mode = 1'b0;
        check_val("echo_no_err", ov_cnt + fe_cnt, 32'd0);

        // 2: TX alone, timing of tready/busy and back-to-back frames.
        clear_mon();
        drv_tdata = 8'hA3; drv_tvalid = 1'b1;
        @(negedge clk);
        check_val("tx_accept_tready", {31'd0, s_tready}, 32'd0);
        check_val("tx_accept_busy", {31'd0, tx_busy}, 32'd1);
        drv_tdata = 8'h3C;
        lo = 1; bz = 1;
        for (int i = 0; i < 400 && s_tready == 1'b0; i++) begin
            @(negedge clk);
            if (!s_tready) lo++;
            if (tx_busy) bz++;
        end
        check_val("tx_tready_low_cycles", lo, 32'd160);
        check_val("tx_busy_cycles", bz, 32'd160);
        @(negedge clk);
        check_val("tx_b2b_start", {31'd0, txd}, 32'd0);
        check_val("tx_b2b_tready", {31'd0, s_tready}, 32'd0);
        drv_tvalid = 1'b0;
        repeat (200) @(negedge clk);
        check_val("tx_frame_count", tx_q.size(), 32'd2);
        if (tx_q.size() == 2) begin
            check_val("tx_frame0", {22'd0, tx_q[0]}, 32'h346);
            check_val("tx_frame1", {22'd0, tx_q[1]}, 32'h278);
        end

        // 3: overrun when the consumer stalls.
        clear_mon();
        drv_mtready = 1'b0;
        send_rx(8'h11, 1'b1); repeat (4) @(negedge clk);
        check_val("ovr_first_valid", {31'd0, m_tvalid}, 32'd1);
        check_val("ovr_first_data", {24'd0, m_tdata}, 32'h11);
        check_val("ovr_none_yet", ov_cnt, 32'd0);
        send_rx(8'h22, 1'b1); repeat (4) @(negedge clk);
        check_val("ovr_pulse_count", ov_cnt, 32'd1);
        check_val("ovr_data", {24'd0, m_tdata}, 32'h22);
        check_val("ovr_valid", {31'd0, m_tvalid}, 32'd1);
        drv_mtready = 1'b1;
        @(negedge clk);
        check_val("ovr_valid_cleared", {31'd0, m_tvalid}, 32'd0);

        // 4: framing error, held break, then a good frame.
        repeat (10) @(negedge clk);
        clear_mon();
        send_rx(8'h5A, 1'b0);
        repeat (100) @(negedge clk);
        check_val("ferr_pulse_count", fe_cnt, 32'd1);
        check_val("ferr_no_valid", vld_cnt, 32'd0);
        check_val("ferr_break_idle", {31'd0, rx_busy}, 32'd0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_rx(8'h3C, 1'b1); repeat (4) @(negedge clk);
        check_val("ferr_next_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check_val("ferr_next_byte", {24'd0, rx_q[0]}, 32'h3C);

        // 5: short low glitch is ignored.
        repeat (10) @(negedge clk);
        clear_mon();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        check_val("glitch_busy", {31'd0, rx_busy}, 32'd1);
        repeat (30) @(negedge clk);
        check_val("glitch_busy_drop", {31'd0, rx_busy}, 32'd0);
        check_val("glitch_quiet", vld_cnt + ov_cnt + fe_cnt, 32'd0);

        // 6: reset in the middle of RX and TX frames.
        drv_tdata = 8'hE7; drv_tvalid = 1'b1; rxd = 1'b0;
        @(negedge clk);
        drv_tvalid = 1'b0;
        repeat (40) @(negedge clk);
        check_val("mid_busy", {30'd0, rx_busy, tx_busy}, 32'd3);
        rst = 1'b1; rxd = 1'b1;
        @(negedge clk);
        check_val("mid_rst_txd", {31'd0, txd}, 32'd1);
        check_val("mid_rst_busy", {30'd0, rx_busy, tx_busy}, 32'd0);
        check_val("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_tready", {31'd0, s_tready}, 32'd1);
        clear_mon();
        fork
            send_rx(8'hC3, 1'b1);
            begin
                drv_tdata = 8'h96; drv_tvalid = 1'b1;
                @(negedge clk);
                drv_tvalid = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        check_val("post_rst_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check_val("post_rst_rx", {24'd0, rx_q[0]}, 32'hC3);
        check_val("post_rst_tx_count", tx_q.size(), 32'd1);
        if (tx_q.size() > 0) check_val("post_rst_tx", {22'd0, tx_q[0]}, 32'h32C);
`endif
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
